// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-boundary registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FULL    = 2'd1,
        SKIDDED = 2'd2
    } stage_state_e;

    // Default payload widths per boundary
    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 104;
    localparam int MEM_WB_W = 72;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline boundary register with flush,
// optional skid entry (registered in_ready) and a stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 96,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter bit                SKID       = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      r_state;
    stage_state_e      w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_skid_q;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main;
    logic              w_main_from_skid;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_fire   = in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = FULL;
                    w_load_main = 1'b1;
                end
            end
            FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire && SKID) begin
                    w_state_nxt = SKIDDED;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            SKIDDED: begin
                if (w_out_fire) begin
                    w_state_nxt      = FULL;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // A flush discards everything, including a same-cycle input
        if (flush) begin
            w_state_nxt = EMPTY;
            w_load_main = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= EMPTY;
            r_main  <= BUBBLE_VAL;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_main <= BUBBLE_VAL;
            end else if (w_load_main) begin
                r_main <= w_main_from_skid ? w_skid_q : in_data;
            end
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] r_skid;
            logic              r_in_ready;
            logic              w_load_skid;

            assign w_load_skid = (r_state == FULL) & w_in_fire
                               & ~w_out_fire & ~flush;

            always_ff @(posedge cpu_clk or posedge cpu_rst) begin
                if (cpu_rst) begin
                    r_skid     <= BUBBLE_VAL;
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != SKIDDED);
                    if (flush) begin
                        r_skid <= BUBBLE_VAL;
                    end else if (w_load_skid) begin
                        r_skid <= in_data;
                    end
                end
            end

            assign w_skid_q   = r_skid;
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid_q   = BUBBLE_VAL;
            assign w_in_ready = ~w_out_valid | out_ready;
        end
    endgenerate

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .i_clk  (cpu_clk),
        .i_rst  (cpu_rst),
        .i_clr  (cnt_clr),
        .i_inc  (w_out_valid & ~out_ready),
        .o_count(stall_cnt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;

endmodule
